keyboard_key_decoder: RTL and testbench

- Parametrised successor to the fixed two-key keyboard controller.
- Consumes the raw PS/2 scan-code byte stream (set 2) from the PS/2 receiver.
- Tracks make/break/extended prefixes with an FSM and maintains held state for a configurable table of keys.
- Emits per-key held levels plus single-cycle press/release pulses to the game-control logic.

---
 rtl/keyboard_pkg.sv | 26 ++
 rtl/keyboard_prefix_fsm.sv | 135 +++++++++++++
 rtl/keyboard_key_decoder.sv | 87 ++++++++
 tb/tb_keyboard_key_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared PS/2 set-2 byte constants, prefix-parser state encoding and key code type
// for the keyboard key decoder.
package keyboard_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;
    localparam logic [7:0] PS2_OVR0  = 8'h00;
    localparam logic [7:0] PS2_OVR1  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_EXT       = 2'd1,
        S_BREAK     = 2'd2,
        S_EXT_BREAK = 2'd3
    } fsm_state_t;

    // Bit 8 flags an E0-prefixed (extended) code, bits 7:0 hold the scan code.
    typedef logic [8:0] key_code_t;

    function automatic logic is_overrun_byte(input logic [7:0] b);
        return (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

endpackage

// File: rtl/keyboard_prefix_fsm.sv
// Parses the PS/2 byte stream into make/break/overrun events, one registered cycle
// after the final byte, abandoning stale prefixes after TIMEOUT_CYCLES idle cycles.
module keyboard_prefix_fsm
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       evt_valid,
    output logic       evt_break,
    output key_code_t  evt_code,
    output logic       evt_overrun
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fsm_state_t       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             evt_valid_r, evt_valid_s;
    logic             evt_break_r, evt_break_s;
    key_code_t        evt_code_r, evt_code_s;
    logic             evt_overrun_r, evt_overrun_s;

    // Next-state, timeout counter and event decode.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        evt_valid_s   = 1'b0;
        evt_break_s   = 1'b0;
        evt_code_s    = 9'h000;
        evt_overrun_s = 1'b0;

        if (rx_valid) begin
            cnt_s = CNT_ZERO;
            if (is_overrun_byte(rx_data)) begin
                state_s       = S_IDLE;
                evt_overrun_s = 1'b1;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (rx_data == PS2_EXT) begin
                            state_s = S_EXT;
                        end else if (rx_data == PS2_BREAK) begin
                            state_s = S_BREAK;
                        end else if ((rx_data == PS2_BAT) || (rx_data == PS2_ACK)) begin
                            state_s = S_IDLE;
                        end else begin
                            evt_valid_s = 1'b1;
                            evt_code_s  = {1'b0, rx_data};
                        end
                    end
                    S_EXT: begin
                        if (rx_data == PS2_BREAK) begin
                            state_s = S_EXT_BREAK;
                        end else if (rx_data == PS2_EXT) begin
                            state_s = S_EXT;
                        end else begin
                            evt_valid_s = 1'b1;
                            evt_code_s  = {1'b1, rx_data};
                            state_s     = S_IDLE;
                        end
                    end
                    S_BREAK: begin
                        if (rx_data == PS2_BREAK) begin
                            state_s = S_BREAK;
                        end else if (rx_data == PS2_EXT) begin
                            state_s = S_EXT;
                        end else begin
                            evt_valid_s = 1'b1;
                            evt_break_s = 1'b1;
                            evt_code_s  = {1'b0, rx_data};
                            state_s     = S_IDLE;
                        end
                    end
                    S_EXT_BREAK: begin
                        if (rx_data == PS2_EXT) begin
                            state_s = S_EXT;
                        end else if (rx_data == PS2_BREAK) begin
                            state_s = S_EXT_BREAK;
                        end else begin
                            evt_valid_s = 1'b1;
                            evt_break_s = 1'b1;
                            evt_code_s  = {1'b1, rx_data};
                            state_s     = S_IDLE;
                        end
                    end
                    default: begin
                        state_s = S_IDLE;
                    end
                endcase
            end
        end else if (state_r != S_IDLE) begin
            // A prefix left dangling too long is dropped without any event.
            if (cnt_r == CNT_LAST) begin
                state_s = S_IDLE;
                cnt_s   = CNT_ZERO;
            end else begin
                cnt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_s = CNT_ZERO;
        end
    end

    // State, counter and event registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            cnt_r         <= CNT_ZERO;
            evt_valid_r   <= 1'b0;
            evt_break_r   <= 1'b0;
            evt_code_r    <= 9'h000;
            evt_overrun_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            evt_valid_r   <= evt_valid_s;
            evt_break_r   <= evt_break_s;
            evt_code_r    <= evt_code_s;
            evt_overrun_r <= evt_overrun_s;
        end
    end

    assign evt_valid   = evt_valid_r;
    assign evt_break   = evt_break_r;
    assign evt_code    = evt_code_r;
    assign evt_overrun = evt_overrun_r;

endmodule

// File: rtl/keyboard_key_decoder.sv
// Applies parsed PS/2 events to a parametrised key table, producing held levels,
// press/release pulses, a registered any-held flag and an overrun pulse.
module keyboard_key_decoder
    import keyboard_pkg::*;
#(
    parameter int                         NUM_KEYS       = 2,
    parameter key_code_t [NUM_KEYS-1:0]   KEY_CODES      = {9'h05A, 9'h029},
    parameter int                         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_held,
    output logic                overrun
);

    logic      evt_valid;
    logic      evt_break;
    key_code_t evt_code;
    logic      evt_overrun;

    logic [NUM_KEYS-1:0] held_r, held_s;
    logic [NUM_KEYS-1:0] press_s, release_s;
    logic [NUM_KEYS-1:0] match_make_s, match_break_s;
    logic                any_held_r;

    keyboard_prefix_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_prefix_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .evt_valid   (evt_valid),
        .evt_break   (evt_break),
        .evt_code    (evt_code),
        .evt_overrun (evt_overrun)
    );

    // Parallel compare of the event code against every table entry.
    always_comb begin
        match_make_s  = {NUM_KEYS{1'b0}};
        match_break_s = {NUM_KEYS{1'b0}};
        for (int i = 0; i < NUM_KEYS; i++) begin
            match_make_s[i]  = evt_valid & ~evt_break & (evt_code == KEY_CODES[i]);
            match_break_s[i] = evt_valid &  evt_break & (evt_code == KEY_CODES[i]);
        end
    end

    // Held-state update; kept combinational on the registered event so the
    // byte-to-output latency stays at one cycle.
    always_comb begin
        held_s    = held_r;
        press_s   = {NUM_KEYS{1'b0}};
        release_s = {NUM_KEYS{1'b0}};
        if (evt_overrun) begin
            release_s = held_r;
            held_s    = {NUM_KEYS{1'b0}};
        end else begin
            press_s   = match_make_s & ~held_r;
            release_s = match_break_s & held_r;
            held_s    = (held_r | match_make_s) & ~match_break_s;
        end
    end

    // Held-state and any-held registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_r     <= {NUM_KEYS{1'b0}};
            any_held_r <= 1'b0;
        end else begin
            held_r     <= held_s;
            any_held_r <= |held_s;
        end
    end

    assign key_held    = held_s;
    assign key_press   = press_s;
    assign key_release = release_s;
    assign any_held    = any_held_r;
    assign overrun     = evt_overrun;

endmodule

// File: tb/tb_keyboard_key_decoder.sv
// Directed self-checking bench for keyboard_key_decoder: default table plus an
// extended-code table instance, both with a short timeout.
module tb_keyboard_key_decoder;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    logic [1:0] key_held, key_press, key_release;
    logic       any_held, overrun;
    logic [1:0] held_x, press_x, release_x;
    logic       any_held_x, overrun_x;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    keyboard_key_decoder #(
        .NUM_KEYS       (2),
        .KEY_CODES      ({9'h05A, 9'h029}),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .key_held    (key_held),
        .key_press   (key_press),
        .key_release (key_release),
        .any_held    (any_held),
        .overrun     (overrun)
    );

    keyboard_key_decoder #(
        .NUM_KEYS       (2),
        .KEY_CODES      ({9'h175, 9'h075}),
        .TIMEOUT_CYCLES (TO)
    ) dut_ext (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .key_held    (held_x),
        .key_press   (press_x),
        .key_release (release_x),
        .any_held    (any_held_x),
        .overrun     (overrun_x)
    );

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    // Drive n bytes on consecutive cycles; returns on the negedge where the last byte's result is visible.
    task automatic send_seq(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] bs [3];
        bs[0] = b0;
        bs[1] = b1;
        bs[2] = b2;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_data  = bs[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        chk("reset_held",    {6'd0, key_held},    8'h00);
        chk("reset_press",   {6'd0, key_press},   8'h00);
        chk("reset_release", {6'd0, key_release}, 8'h00);
        chk("reset_any",     {7'd0, any_held},    8'h00);
        chk("reset_overrun", {7'd0, overrun},     8'h00);
    endtask

    task automatic test_single_space;
        send_seq(1, 8'h29, 8'h00, 8'h00);
        chk("space_held",  {6'd0, key_held},  8'h01);
        chk("space_press", {6'd0, key_press}, 8'h01);
        chk("space_any_lag", {7'd0, any_held}, 8'h00);
        idle(1);
        chk("space_press_end", {6'd0, key_press}, 8'h00);
        chk("space_any",       {7'd0, any_held},  8'h01);
        send_seq(2, 8'hF0, 8'h29, 8'h00);
        chk("space_rel_held", {6'd0, key_held},    8'h00);
        chk("space_release",  {6'd0, key_release}, 8'h01);
        idle(1);
        chk("space_release_end", {6'd0, key_release}, 8'h00);
        chk("space_any_fall",    {7'd0, any_held},    8'h00);
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [5];
        int n_press = 0;
        int n_rel = 0;
        int n_held = 0;
        seq[0] = 8'h5A; seq[1] = 8'h5A; seq[2] = 8'h5A; seq[3] = 8'hF0; seq[4] = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_press += int'(key_press[1]);
            n_rel   += int'(key_release[1]);
            n_held  += int'(key_held[1]);
            if (i < 5) begin
                rx_data  = seq[i];
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
                rx_data  = 8'h00;
            end
        end
        chk("typematic_press_cnt",   8'(n_press), 8'd1);
        chk("typematic_release_cnt", 8'(n_rel),   8'd1);
        chk("typematic_held_cycles", 8'(n_held),  8'd4);
        chk("typematic_end_held", {6'd0, key_held}, 8'h00);
    endtask

    task automatic test_extended;
        send_seq(2, 8'hE0, 8'h75, 8'h00);
        chk("ext_make_held",  {6'd0, held_x},  8'h02);
        chk("ext_make_press", {6'd0, press_x}, 8'h02);
        send_seq(1, 8'h75, 8'h00, 8'h00);
        chk("plain_make_held",  {6'd0, held_x},  8'h03);
        chk("plain_make_press", {6'd0, press_x}, 8'h01);
        send_seq(3, 8'hE0, 8'hF0, 8'h75);
        chk("ext_break_held",    {6'd0, held_x},    8'h01);
        chk("ext_break_release", {6'd0, release_x}, 8'h02);
        send_seq(2, 8'hF0, 8'h75, 8'h00);
        chk("plain_break_held", {6'd0, held_x}, 8'h00);
    endtask

    task automatic test_timeout;
        send_seq(1, 8'h29, 8'h00, 8'h00);
        send_seq(1, 8'hF0, 8'h00, 8'h00);
        idle(TO + 5);
        send_seq(1, 8'h29, 8'h00, 8'h00);
        chk("timeout_held",    {6'd0, key_held},    8'h01);
        chk("timeout_press",   {6'd0, key_press},   8'h00);
        chk("timeout_release", {6'd0, key_release}, 8'h00);
        send_seq(1, 8'hF0, 8'h00, 8'h00);
        idle(TO / 2);
        send_seq(1, 8'h29, 8'h00, 8'h00);
        chk("no_timeout_release", {6'd0, key_release}, 8'h01);
        chk("no_timeout_held",    {6'd0, key_held},    8'h00);
    endtask

    task automatic test_overrun;
        send_seq(2, 8'h29, 8'h5A, 8'h00);
        chk("ovr_pre_held", {6'd0, key_held}, 8'h03);
        send_seq(1, 8'hFF, 8'h00, 8'h00);
        chk("ovr_pulse",   {7'd0, overrun},     8'h01);
        chk("ovr_release", {6'd0, key_release}, 8'h03);
        chk("ovr_held",    {6'd0, key_held},    8'h00);
        chk("ovr_any_lag", {7'd0, any_held},    8'h01);
        idle(1);
        chk("ovr_pulse_end",   {7'd0, overrun},     8'h00);
        chk("ovr_release_end", {6'd0, key_release}, 8'h00);
        chk("ovr_any_fall",    {7'd0, any_held},    8'h00);
        send_seq(2, 8'hE0, 8'h00, 8'h00);
        chk("ovr_mid_pulse",   {7'd0, overrun},     8'h01);
        chk("ovr_mid_release", {6'd0, key_release}, 8'h00);
        send_seq(1, 8'h29, 8'h00, 8'h00);
        chk("ovr_then_plain", {6'd0, key_held}, 8'h01);
        send_seq(2, 8'hF0, 8'h29, 8'h00);
    endtask

    task automatic test_ignored;
        send_seq(2, 8'hAA, 8'hFA, 8'h00);
        chk("ignored_press", {6'd0, key_press}, 8'h00);
        chk("ignored_ovr",   {7'd0, overrun},   8'h00);
        send_seq(1, 8'h5A, 8'h00, 8'h00);
        chk("after_ignored_make", {6'd0, key_press}, 8'h02);
        send_seq(2, 8'hF0, 8'h5A, 8'h00);
    endtask

    task automatic test_reset_mid;
        send_seq(1, 8'h75, 8'h00, 8'h00);
        chk("rstmid_pre_held", {6'd0, held_x}, 8'h01);
        send_seq(2, 8'hE0, 8'hF0, 8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_held_x", {6'd0, held_x},     8'h00);
        chk("rstmid_any_x",  {7'd0, any_held_x}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        send_seq(1, 8'h75, 8'h00, 8'h00);
        chk("rstmid_plain_held",  {6'd0, held_x},  8'h01);
        chk("rstmid_plain_press", {6'd0, press_x}, 8'h01);
    endtask

    initial begin
        #2;
        test_reset;
        idle(2);
        rst_n = 1'b1;
        test_single_space;
        test_back_to_back;
        test_extended;
        test_timeout;
        test_overrun;
        test_ignored;
        test_reset_mid;
        idle(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
